// File: rtl/ps2_key_event_queue_if.sv
// Key-event stream between the PS/2 decoder and its consumer.
// Handshake: valid/ready; data = {ext, brk, code[7:0]}.
interface ps2_key_event_queue_if;
  logic       valid;
  logic       ready;
  logic [9:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 keyboard front end: filtered receiver, prefix assembler,
// held-key repeat filter and an event FIFO drained over valid/ready.
// rx state | meaning           asm state | meaning
// IDLE     | wait start bit    IDLE      | no prefix seen
// DATA     | 8 data bits       E0 / F0   | extended / break prefix
// PARITY   | odd parity bit    E0F0      | extended break prefix
// STOP     | stop bit          PAUSE     | swallowing the E1 pause sequence
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_HELD        = 6,
  parameter int SUPPRESS_REPEAT = 1,
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYC     = 50000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          en_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  ps2_key_event_queue_if.master         evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [$clog2(MAX_HELD+1)-1:0] held_count_o,
  output logic                          overrun_o,
  output logic                          held_ovf_o,
  output logic [7:0]                    frame_err_cnt_o,
  input  logic                          clr_err_i
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int HCW = $clog2(MAX_HELD + 1);
  localparam int HIW = (MAX_HELD > 1) ? $clog2(MAX_HELD) : 1;
  localparam int FW  = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LOAD  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {AS_IDLE, AS_E0, AS_F0, AS_E0F0, AS_PAUSE} as_state_e;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          flt_clk_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall;

  // Synchronisers idle high so a reset during bus idle creates no edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      flt_clk_q   <= 1'b1;
      flt_cnt_q   <= FLT_LOAD;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (clk_sync_q[1] == flt_clk_q) begin
        flt_cnt_q <= FLT_LOAD;
      end else if (flt_cnt_q == '0) begin
        flt_clk_q <= clk_sync_q[1];
        flt_cnt_q <= FLT_LOAD;
      end else begin
        flt_cnt_q <= flt_cnt_q - 1'b1;
      end
    end
  end

  assign fall = flt_clk_q && !clk_sync_q[1] && (flt_cnt_q == '0);

  rx_state_e     rx_state_q, rx_state_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [2:0]    rx_bcnt_q, rx_bcnt_d;
  logic          rx_par_q, rx_par_d;
  logic [TW-1:0] rx_tmr_q, rx_tmr_d;
  logic          rx_stb_q, rx_stb_d;
  logic          rx_err;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_state_q <= RX_IDLE;
      rx_sr_q    <= '0;
      rx_bcnt_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_tmr_q   <= TMR_LOAD;
      rx_stb_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sr_q    <= rx_sr_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_par_q   <= rx_par_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_stb_q   <= rx_stb_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sr_d    = rx_sr_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_par_d   = rx_par_q;
    rx_tmr_d   = (rx_tmr_q != '0) ? rx_tmr_q - 1'b1 : rx_tmr_q;
    rx_stb_d   = 1'b0;
    rx_err     = 1'b0;
    if (fall) rx_tmr_d = TMR_LOAD;
    if (!en_i) begin
      rx_state_d = RX_IDLE;
      rx_tmr_d   = TMR_LOAD;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_tmr_d = TMR_LOAD;
          if (fall && !data_sync_q[1]) begin
            rx_state_d = RX_DATA;
            rx_bcnt_d  = '0;
          end
        end
        RX_DATA: if (fall) begin
          rx_sr_d   = {data_sync_q[1], rx_sr_q[7:1]};
          rx_bcnt_d = rx_bcnt_q + 1'b1;
          if (rx_bcnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: if (fall) begin
          rx_par_d   = data_sync_q[1];
          rx_state_d = RX_STOP;
        end
        RX_STOP: if (fall) begin
          rx_state_d = RX_IDLE;
          if (data_sync_q[1] && (^{rx_sr_q, rx_par_q})) rx_stb_d = 1'b1;
          else                                          rx_err   = 1'b1;
        end
        default: rx_state_d = RX_IDLE;
      endcase
      if (rx_state_q != RX_IDLE && !fall && rx_tmr_q == '0) begin
        rx_state_d = RX_IDLE;
        rx_err     = 1'b1;
      end
    end
  end

  as_state_e  as_state_q, as_state_d;
  logic [2:0] pause_cnt_q, pause_cnt_d;
  logic       pend_vld_q, pend_vld_d;
  logic       pend_raw_q, pend_raw_d;
  logic [9:0] pend_data_q, pend_data_d;
  logic       as_ext, as_brk;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      as_state_q  <= AS_IDLE;
      pause_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_raw_q  <= 1'b0;
      pend_data_q <= '0;
    end else begin
      as_state_q  <= as_state_d;
      pause_cnt_q <= pause_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_raw_q  <= pend_raw_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign as_ext = (as_state_q == AS_E0) || (as_state_q == AS_E0F0);
  assign as_brk = (as_state_q == AS_F0) || (as_state_q == AS_E0F0);

  // Pause has no break code, so its event bypasses the held-key table.
  always_comb begin
    as_state_d  = as_state_q;
    pause_cnt_d = pause_cnt_q;
    pend_vld_d  = 1'b0;
    pend_raw_d  = 1'b0;
    pend_data_d = pend_data_q;
    if (!en_i) begin
      as_state_d = AS_IDLE;
    end else if (rx_stb_q) begin
      if (as_state_q == AS_PAUSE) begin
        if (pause_cnt_q == '0) begin
          as_state_d  = AS_IDLE;
          pend_vld_d  = 1'b1;
          pend_raw_d  = 1'b1;
          pend_data_d = {2'b10, 8'h77};
        end else begin
          pause_cnt_d = pause_cnt_q - 1'b1;
        end
      end else if (rx_sr_q == 8'hE0) begin
        as_state_d = AS_E0;
      end else if (rx_sr_q == 8'hF0) begin
        as_state_d = as_ext ? AS_E0F0 : AS_F0;
      end else if (rx_sr_q == 8'hE1) begin
        as_state_d  = AS_PAUSE;
        pause_cnt_d = 3'd6;
      end else if (!(as_state_q == AS_IDLE &&
                     rx_sr_q inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE})) begin
        as_state_d  = AS_IDLE;
        pend_vld_d  = 1'b1;
        pend_data_d = {as_ext, as_brk, rx_sr_q};
      end
    end
  end

  logic [MAX_HELD-1:0] held_vld_q;
  logic [8:0]          held_key_q [MAX_HELD];
  logic [HCW-1:0]      held_cnt_q;
  logic [8:0]          key;
  logic                hit, free_ok, ins, rem, hovf_set, push_req;
  logic [HIW-1:0]      hit_idx, free_idx;

  assign key = {pend_data_q[9], pend_data_q[7:0]};

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = 0; i < MAX_HELD; i++) begin
      if (held_vld_q[i] && held_key_q[i] == key) begin
        hit     = 1'b1;
        hit_idx = HIW'(i);
      end
      if (!held_vld_q[i]) begin
        free_ok  = 1'b1;
        free_idx = HIW'(i);
      end
    end
  end

  always_comb begin
    push_req = 1'b0;
    ins      = 1'b0;
    rem      = 1'b0;
    hovf_set = 1'b0;
    if (pend_vld_q && en_i) begin
      if (pend_raw_q) begin
        push_req = 1'b1;
      end else if (pend_data_q[8]) begin
        push_req = 1'b1;
        rem      = hit;
      end else if (hit) begin
        push_req = (SUPPRESS_REPEAT == 0);
      end else begin
        push_req = 1'b1;
        ins      = free_ok;
        hovf_set = !free_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_vld_q <= '0;
      held_cnt_q <= '0;
      for (int i = 0; i < MAX_HELD; i++) held_key_q[i] <= '0;
    end else if (!en_i) begin
      held_vld_q <= '0;
      held_cnt_q <= '0;
    end else if (ins) begin
      held_vld_q[free_idx] <= 1'b1;
      held_key_q[free_idx] <= key;
      held_cnt_q           <= held_cnt_q + 1'b1;
    end else if (rem) begin
      held_vld_q[hit_idx] <= 1'b0;
      held_cnt_q          <= held_cnt_q - 1'b1;
    end
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          pop, push_ok, ovr_set;
  logic          overrun_q, held_ovf_q;
  logic [7:0]    err_cnt_q;

  assign pop     = evt.valid && evt.ready;
  assign push_ok = push_req && ((cnt_q != FIFO_FULL) || pop);
  assign ovr_set = push_req && (cnt_q == FIFO_FULL) && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= pend_data_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // A clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overrun_q  <= 1'b0;
      held_ovf_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (clr_err_i) begin
      overrun_q  <= 1'b0;
      held_ovf_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (ovr_set)  overrun_q  <= 1'b1;
      if (hovf_set) held_ovf_q <= 1'b1;
      if (rx_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign evt.valid       = (cnt_q != '0);
  assign evt.data        = evt.valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count_o    = cnt_q;
  assign held_count_o    = held_cnt_q;
  assign overrun_o       = overrun_q;
  assign held_ovf_o      = held_ovf_q;
  assign frame_err_cnt_o = err_cnt_q;
endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Parametrised successor to the single-register PS/2 keyboard decoder.
- Receives raw PS/2 frames and assembles scan-code-set-2 prefixes (E0, F0, E1 pause) into key events.
- Tracks held keys so that typematic repeats are dropped.
- Buffers events in a FIFO drained by a valid/ready consumer (game input logic, CPU MMIO bridge).

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, >=2.
- MAX_HELD, 6: held-key table entries.
- SUPPRESS_REPEAT, 1: 1 drops make events for already-held keys.
- FILTER_LEN, 8: consecutive equal samples required to accept a ps2_clk level change.
- TIMEOUT_CYC, 50000: idle clk cycles mid-frame before the receiver aborts the frame (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- en  in  1  block enable.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_data  out  10  {ext, brk, code[7:0]} at the FIFO head.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- held_count  out  $clog2(MAX_HELD+1)  keys currently held.
- overrun  out  1  sticky: event dropped because the FIFO was full.
- held_ovf  out  1  sticky: make arrived while the held table was full.
- frame_err_cnt  out  8  saturating count of bad frames.
- clr_err  in  1  one-cycle pulse clears overrun, held_ovf and frame_err_cnt.

Behaviour:
- Reset (clrn=0, async): all outputs 0, FIFO empty, held table empty, every FSM in IDLE.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - A ps2_clk level change is accepted after FILTER_LEN equal samples.
  - A bit is sampled on each accepted falling edge.
- Receiver FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: start bit 1 -> stay in IDLE, no error counted.
  - Data is 8 bits, LSB first.
  - Parity is odd over data+parity; stop bit must be 1.
  - Parity or stop failure -> byte discarded, frame_err_cnt+1 (saturates at 255).
  - Mid-frame, TIMEOUT_CYC cycles without an accepted edge -> return to IDLE, frame_err_cnt+1.
  - A good stop bit yields a byte strobe in cycle N.
- Assembler FSM (IDLE, E0, F0, E0F0, PAUSE), updated in cycle N+1:
  - 00, FF, AA, FA, EE, FE in IDLE: discarded.
  - E0 -> E0; F0 from IDLE -> F0; F0 from E0 -> E0F0.
  - Any other byte: event {ext, brk, byte} with ext=1 from E0/E0F0 and brk=1 from F0/E0F0; FSM returns to IDLE.
  - E1 -> PAUSE: swallow the next 7 bytes, then emit one event {1,0,8'h77}.
  - Unexpected E0/F0 in PAUSE: still counted as swallowed bytes.
- Held table (key = {ext, code}):
  - Make, key present, SUPPRESS_REPEAT=1 -> event dropped.
  - Make, key absent, table has room -> key inserted, event emitted.
  - Make, key absent, table full -> event emitted, held_ovf set, key not stored.
  - Break -> matching entry removed if present; event always emitted.
  - held_count is updated in the same cycle as the event push.
- FIFO:
  - Push occurs in cycle N+1; evt_valid/evt_data visible from N+2.
  - Pop occurs when evt_valid && evt_ready at a rising edge.
  - Push while full and no pop -> event dropped, overrun set.
  - Push while full with a same-cycle pop -> push accepted, count stays FIFO_DEPTH.
  - Push and pop while empty -> no pop; count becomes 1.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - evt_data holds its value while evt_valid=1 and evt_ready=0.
- en=0:
  - Receiver and assembler forced to IDLE; bytes are ignored.
  - Held table cleared, held_count=0.
  - FIFO contents and popping unaffected.
- clr_err in the same cycle as a new error: clear wins; the error is lost.

Test Plan:
- Frames 1C, F0 1C with evt_ready=1 -> events 0x01C then 0x11C; held_count goes 1 then 0; each evt_valid rises 2 cycles after the stop-bit byte strobe.
- Frames 1C 1C 1C (typematic), SUPPRESS_REPEAT=1 -> exactly one event 0x01C; with SUPPRESS_REPEAT=0 -> three events.
- Frames E0 75, E0 F0 75 -> events 0x275, 0x375; E1 14 77 E1 F0 14 F0 77 -> single event 0x277, no other events.
- Frame with bad parity, then a frame stalled after 4 data bits for TIMEOUT_CYC cycles -> frame_err_cnt=2, no events, next good frame 2B -> event 0x02B.
- evt_ready=0, FIFO_DEPTH+1 distinct makes (MAX_HELD=6, FIFO_DEPTH=8) -> fifo_count=8, overrun=1, held_ovf=1; first 8 events drain in order; clr_err -> all sticky flags 0.
- Assert clrn low mid-frame with 3 events queued -> evt_valid=0, fifo_count=0, held_count=0 immediately; the next full frame decodes correctly.
